// File: rtl/vga_pkg.sv
// Shared definitions for the VGA LED display register: CPU address map and
// the commit state encoding.
package vga_pkg;

    localparam logic [31:0] ADDR_DATA = 32'hFFFF_FC90;
    localparam logic [31:0] ADDR_CTRL = 32'hFFFF_FC94;
    localparam logic [31:0] ADDR_STAT = 32'hFFFF_FC98;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } disp_state_e;

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchroniser for the active-low vertical sync, plus a history flop
// so a high-to-low transition yields a single-cycle fall strobe.
module vs_edge_sync (
    input  logic sys_clk,
    input  logic rst,
    input  logic async_in,
    output logic fall
);

    logic r_vs_s1;
    logic r_vs_s2;
    logic r_vs_s3;

    // Sync flops reset high (sync inactive) so reset release alone is never an edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_vs_s1 <= 1'b1;
            r_vs_s2 <= 1'b1;
            r_vs_s3 <= 1'b0;
        end else begin
            r_vs_s1 <= async_in;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
        end
    end

    assign fall = r_vs_s3 & ~r_vs_s2;

endmodule

// File: rtl/vga_disp_reg.sv
// CPU-visible shadow register for the LED display; the shadow is committed to
// led_disp on vertical sync, or at once in immediate mode.
//
//   state | meaning
//   IDLE  | led_disp matches the last accepted write, nothing to commit
//   PEND  | shadow holds a value waiting for the next unfrozen vs_fall
module vga_disp_reg
    import vga_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        vga_vs,
    output logic [15:0] led_disp,
    output logic [31:0] rdata,
    output logic        rd_hit,
    output logic        pending,
    output logic        commit_pulse
);

    disp_state_e r_state;
    disp_state_e w_state_nxt;

    logic [15:0] r_shadow;
    logic [15:0] r_led_disp;
    logic        r_ctrl_freeze;
    logic        r_ctrl_imm;
    logic        r_commit_pulse;

    logic        w_vs_fall;
    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_imm_commit;
    logic        w_vs_commit;
    logic        w_commit;
    logic [15:0] w_commit_val;
    logic        w_unused;

    vs_edge_sync u_vs_edge_sync (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .async_in (vga_vs),
        .fall     (w_vs_fall)
    );

    assign w_data_wr = mem_write && (addr == ADDR_DATA);
    assign w_ctrl_wr = mem_write && (addr == ADDR_CTRL);

    // Ctrl fields are read from the registers, so a ctrl write landing on a
    // vs_fall cycle only affects later decisions.
    assign w_imm_commit = w_data_wr & r_ctrl_imm;
    assign w_vs_commit  = w_vs_fall & ~r_ctrl_freeze &
                          ((r_state == PEND) | (w_data_wr & ~r_ctrl_imm));
    assign w_commit     = w_imm_commit | w_vs_commit;
    assign w_commit_val = w_data_wr ? wdata[15:0] : r_shadow;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_data_wr && !w_commit) w_state_nxt = PEND;
            PEND: if (w_commit)               w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_shadow       <= 16'h0;
            r_led_disp     <= 16'h0;
            r_ctrl_freeze  <= 1'b0;
            r_ctrl_imm     <= 1'b0;
            r_commit_pulse <= 1'b0;
        end else begin
            if (w_data_wr) begin
                r_shadow <= wdata[15:0];
            end
            if (w_ctrl_wr) begin
                r_ctrl_freeze <= wdata[0];
                r_ctrl_imm    <= wdata[1];
            end
            if (w_commit) begin
                r_led_disp <= w_commit_val;
            end
            r_commit_pulse <= w_commit;
        end
    end

    always_comb begin
        rdata  = 32'h0;
        rd_hit = 1'b0;
        case (addr)
            ADDR_DATA: begin
                rdata  = {16'h0, r_shadow};
                rd_hit = 1'b1;
            end
            ADDR_CTRL: begin
                rdata  = {30'h0, r_ctrl_imm, r_ctrl_freeze};
                rd_hit = 1'b1;
            end
            ADDR_STAT: begin
                rdata  = {31'h0, pending};
                rd_hit = 1'b1;
            end
            default: begin
                rdata  = 32'h0;
                rd_hit = 1'b0;
            end
        endcase
    end

    assign led_disp     = r_led_disp;
    assign pending      = (r_state == PEND);
    assign commit_pulse = r_commit_pulse;

    // Only the low half of store data is architecturally meaningful.
    assign w_unused = &{1'b0, wdata[31:16]};

endmodule

// File: tb/tb_vga_disp_reg.sv
// Directed bench for vga_disp_reg: deferred, frozen, immediate, bypass and
// reset scenarios with hand-computed expectations, checked on falling edges.
module tb_vga_disp_reg;

    localparam logic [31:0] A_DATA  = 32'hFFFF_FC90;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_FC94;
    localparam logic [31:0] A_STAT  = 32'hFFFF_FC98;
    localparam logic [31:0] A_UNMAP = 32'hFFFF_FC9C;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        vga_vs;
    logic [15:0] led_disp;
    logic [31:0] rdata;
    logic        rd_hit;
    logic        pending;
    logic        commit_pulse;

    int n_vec = 0;
    int n_err = 0;

    vga_disp_reg dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .mem_write    (mem_write),
        .addr         (addr),
        .wdata        (wdata),
        .vga_vs       (vga_vs),
        .led_disp     (led_disp),
        .rdata        (rdata),
        .rd_hit       (rd_hit),
        .pending      (pending),
        .commit_pulse (commit_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store lasting one cycle; returns on the falling edge after the capture edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        addr      = a;
        wdata     = d;
        @(negedge sys_clk);
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
    endtask

    // Drive sync low and stop on the falling edge just after the commit edge.
    task automatic vs_low_to_commit();
        vga_vs = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic vs_high();
        vga_vs = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic exp_hit);
        addr = a;
        #1;
        chk({tag, "_rdata"}, rdata, exp_d);
        chk({tag, "_hit"}, {31'h0, rd_hit}, {31'h0, exp_hit});
        addr = 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        vga_vs    = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;

        chk("rst_led", {16'h0, led_disp}, 32'h0);
        chk("rst_pending", {31'h0, pending}, 32'h0);
        chk("rst_commit", {31'h0, commit_pulse}, 32'h0);
        rd("rst_ctrl", A_CTRL, 32'h0, 1'b1);

        // deferred commit
        wr(A_DATA, 32'hFFFF_A5A5);
        chk("def_pend0", {31'h0, pending}, 32'h1);
        chk("def_led0", {16'h0, led_disp}, 32'h0);
        vga_vs = 1'b0;
        @(negedge sys_clk);
        chk("def_pend1", {31'h0, pending}, 32'h1);
        @(negedge sys_clk);
        chk("def_pend2", {31'h0, pending}, 32'h1);
        chk("def_cp2", {31'h0, commit_pulse}, 32'h0);
        @(negedge sys_clk);
        chk("def_led3", {16'h0, led_disp}, 32'h0000_A5A5);
        chk("def_cp3", {31'h0, commit_pulse}, 32'h1);
        chk("def_pend3", {31'h0, pending}, 32'h0);
        @(negedge sys_clk);
        chk("def_cp4", {31'h0, commit_pulse}, 32'h0);
        vs_high();
        rd("def_shadow", A_DATA, 32'h0000_A5A5, 1'b1);
        rd("def_stat", A_STAT, 32'h0, 1'b1);

        // freeze holds the value through three sync falls
        wr(A_CTRL, 32'h1);
        wr(A_DATA, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            vs_low_to_commit();
            chk("frz_cp", {31'h0, commit_pulse}, 32'h0);
            vs_high();
        end
        chk("frz_led", {16'h0, led_disp}, 32'h0000_A5A5);
        chk("frz_pend", {31'h0, pending}, 32'h1);
        rd("frz_stat", A_STAT, 32'h1, 1'b1);
        wr(A_CTRL, 32'h0);
        vs_low_to_commit();
        chk("unfrz_led", {16'h0, led_disp}, 32'h0000_1234);
        chk("unfrz_cp", {31'h0, commit_pulse}, 32'h1);
        chk("unfrz_pend", {31'h0, pending}, 32'h0);
        vs_high();

        // immediate mode, including back-to-back writes and ignored freeze
        wr(A_CTRL, 32'h2);
        wr(A_DATA, 32'h00FF);
        chk("imm_led", {16'h0, led_disp}, 32'h0000_00FF);
        chk("imm_cp", {31'h0, commit_pulse}, 32'h1);
        chk("imm_pend", {31'h0, pending}, 32'h0);
        wr(A_DATA, 32'h0F0F);
        chk("imm_b2b_led", {16'h0, led_disp}, 32'h0000_0F0F);
        chk("imm_b2b_cp", {31'h0, commit_pulse}, 32'h1);
        wr(A_CTRL, 32'h3);
        wr(A_DATA, 32'hABCD);
        chk("imm_frz_led", {16'h0, led_disp}, 32'h0000_ABCD);
        chk("imm_frz_pend", {31'h0, pending}, 32'h0);
        rd("rb_ctrl", A_CTRL, 32'h3, 1'b1);
        rd("rb_unmap", A_UNMAP, 32'h0, 1'b0);
        wr(A_STAT, 32'hFFFF_FFFF);
        wr(A_UNMAP, 32'h0000_1111);
        rd("ign_shadow", A_DATA, 32'h0000_ABCD, 1'b1);
        chk("ign_led", {16'h0, led_disp}, 32'h0000_ABCD);
        chk("ign_pend", {31'h0, pending}, 32'h0);
        wr(A_CTRL, 32'h0);

        // data write on the exact vs_fall cycle commits the new data
        vga_vs = 1'b0;
        repeat (2) @(negedge sys_clk);
        wr(A_DATA, 32'hBEEF);
        chk("sim_led", {16'h0, led_disp}, 32'h0000_BEEF);
        chk("sim_cp", {31'h0, commit_pulse}, 32'h1);
        chk("sim_pend", {31'h0, pending}, 32'h0);
        vs_high();

        // vs_fall in IDLE does nothing
        vs_low_to_commit();
        chk("idle_cp", {31'h0, commit_pulse}, 32'h0);
        chk("idle_led", {16'h0, led_disp}, 32'h0000_BEEF);
        vs_high();

        // ctrl write on the vs_fall cycle: old ctrl decides
        wr(A_DATA, 32'h7777);
        vga_vs = 1'b0;
        repeat (2) @(negedge sys_clk);
        wr(A_CTRL, 32'h1);
        chk("cw_old0_led", {16'h0, led_disp}, 32'h0000_7777);
        chk("cw_old0_cp", {31'h0, commit_pulse}, 32'h1);
        vs_high();
        wr(A_DATA, 32'h8888);
        vga_vs = 1'b0;
        repeat (2) @(negedge sys_clk);
        wr(A_CTRL, 32'h0);
        chk("cw_old1_led", {16'h0, led_disp}, 32'h0000_7777);
        chk("cw_old1_cp", {31'h0, commit_pulse}, 32'h0);
        chk("cw_old1_pend", {31'h0, pending}, 32'h1);
        vs_high();
        vs_low_to_commit();
        chk("cw_next_led", {16'h0, led_disp}, 32'h0000_8888);
        chk("cw_next_cp", {31'h0, commit_pulse}, 32'h1);
        vs_high();

        // reset while pending discards the shadow
        wr(A_DATA, 32'h5555);
        chk("rp_pend0", {31'h0, pending}, 32'h1);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        rd("rp_shadow", A_DATA, 32'h0, 1'b1);
        vs_low_to_commit();
        chk("rp_led", {16'h0, led_disp}, 32'h0);
        chk("rp_pend", {31'h0, pending}, 32'h0);
        chk("rp_cp", {31'h0, commit_pulse}, 32'h0);
        vs_high();

        // sync held low across reset release
        vga_vs = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            chk("rl_cp", {31'h0, commit_pulse}, 32'h0);
        end
        chk("rl_led", {16'h0, led_disp}, 32'h0);
        chk("rl_pend", {31'h0, pending}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_disp_reg.md
VGA_DISP_REG -- requirements
Module: vga_disp_reg

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, using these ports: sys_clk  input  1  system clock; rst  input  1  reset.
REQ-002 The block SHALL have the following remaining ports (name  direction  width  meaning):
  mem_write  input  1  CPU store strobe, valid for one sys_clk cycle.
  addr  input  32  CPU byte address.
  wdata  input  32  CPU store data.
  vga_vs  input  1  vertical sync from the display path, active low, asynchronous to sys_clk.
  led_disp  output  16  value driven to the display path's led input.
  rdata  output  32  combinational readback.
  rd_hit  output  1  high when addr matches any register.
  pending  output  1  the shadow register holds an uncommitted value.
  commit_pulse  output  1  one-cycle strobe on the cycle led_disp updates.
REQ-003 The block SHALL use these address constants (name, default, meaning):
  ADDR_DATA, 32'hFFFF_FC90, shadow data.
  ADDR_CTRL, 32'hFFFF_FC94, control.
  ADDR_STAT, 32'hFFFF_FC98, status.

Function
REQ-004 The block SHALL load wdata[15:0] into the 16-bit shadow register on a write (mem_write=1) to ADDR_DATA; the upper data bits SHALL be ignored.
REQ-005 The block SHALL load ctrl_freeze=wdata[0] and ctrl_imm=wdata[1] on a write to ADDR_CTRL.
REQ-006 The block SHALL ignore writes to ADDR_STAT and to unmapped addresses.
REQ-007 The block SHALL synchronise vga_vs through two flops (vs_s1, vs_s2) followed by a history flop vs_s3.
REQ-008 The block SHALL define vs_fall = vs_s3 & ~vs_s2.
REQ-009 On a vs_fall cycle, the block SHALL register commit_pulse=1 and load led_disp at the same clock edge.
REQ-010 Commit latency SHALL be 3 sys_clk edges from the first edge that samples vga_vs low.
REQ-011 The block SHALL have a state machine with two states: IDLE (pending=0) and PEND (pending=1).
REQ-012 IDLE SHALL go to PEND on a data write when ctrl_imm=0.
REQ-013 PEND SHALL go to IDLE on a commit, i.e. vs_fall & ~ctrl_freeze.
REQ-014 PEND SHALL remain in PEND on further data writes, with the shadow overwritten (last write wins).
REQ-015 With ctrl_freeze=1, the block SHALL suppress all vs_fall commits, keep led_disp unchanged and keep the state in PEND.
REQ-016 Clearing ctrl_freeze SHALL allow the next vs_fall to commit.
REQ-017 With ctrl_imm=1, a data write SHALL load both the shadow and led_disp at the next edge, assert commit_pulse for that cycle and leave the state in IDLE.
REQ-018 In immediate mode, ctrl_freeze SHALL be ignored.
REQ-019 When a data write and a vs_fall occur in the same cycle with ctrl_imm=0 and freeze=0, the commit SHALL use the wdata[15:0] being written (bypass), and the state SHALL end in IDLE.
REQ-020 When a ctrl write and a vs_fall occur in the same cycle, the commit decision SHALL use the ctrl values held before the write.
REQ-021 A vs_fall in IDLE SHALL produce no commit_pulse and leave led_disp unchanged.
REQ-022 Readback SHALL return:
  ADDR_DATA -> {16'h0, shadow}.
  ADDR_CTRL -> {30'h0, ctrl_imm, ctrl_freeze}.
  ADDR_STAT -> {31'h0, pending}.
  Any other address -> 0, with rd_hit=0.
REQ-023 commit_pulse SHALL never be high on two consecutive cycles, except for back-to-back immediate-mode writes.

Reset
REQ-024 Synchronous rst=1 SHALL clear shadow, led_disp, ctrl_freeze, ctrl_imm, commit_pulse and vs_s3 to 0, set vs_s1 and vs_s2 to 1, and force the state to IDLE.
REQ-025 A reset asserted while in PEND SHALL discard the uncommitted shadow value.
REQ-026 A vga_vs low level present at reset release SHALL NOT cause a commit.

Structure
REQ-027 The address constants and the state encoding (IDLE=1'b0, PEND=1'b1) SHALL reside in the shared package vga_pkg.
REQ-028 The synchroniser and edge detector SHALL be one sub-module, vs_edge_sync (inputs sys_clk, rst, async_in; output fall).
REQ-029 Only registered outputs SHALL feed led_disp.

Verification
REQ-030 The bench SHALL cover a deferred commit: write 16'hA5A5 to ADDR_DATA, then drive vga_vs low -> pending=1 until the 3rd edge, then led_disp=A5A5, commit_pulse for 1 cycle, pending=0.
REQ-031 The bench SHALL cover freeze: write ctrl=1, write data 16'h1234, run 3 vs_fall events -> led_disp unchanged and pending=1; then write ctrl=0 -> the next vs_fall commits 1234.
REQ-032 The bench SHALL cover immediate mode: write ctrl=2, then data 16'h00FF -> led_disp=00FF at the next edge, commit_pulse=1, pending=0.
REQ-033 The bench SHALL cover a simultaneous event: write 16'hBEEF on the exact vs_fall cycle -> led_disp=BEEF, state IDLE.
REQ-034 The bench SHALL cover reset mid-pending: write 16'h5555, assert rst for 1 cycle, then run vs_fall -> led_disp=0, pending=0, no commit_pulse.
REQ-035 The bench SHALL cover readback: addr=FFFF_FC94 after ctrl=3 -> rdata=3 and rd_hit=1; addr=FFFF_FC9C -> rdata=0 and rd_hit=0.
